// File: rtl/ccs_port_pkg.sv
// Shared helpers for the ccs_* stream port family.
package ccs_port_pkg;

  function automatic int ccs_clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v * 2;
      r = r + 1;
    end
    return r;
  endfunction

  // Wrap by explicit compare so non-power-of-two depths work.
  function automatic int ccs_ptr_inc(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/ccs_fifo_ctrl.sv
// Pointer and occupancy bookkeeping for ccs_out_wait_fifo.
// Reset beats flush; flush discards any push or pop in the same cycle.
module ccs_fifo_ctrl
  import ccs_port_pkg::*;
#(
  parameter int depth = 2,
  localparam int aw = (depth > 1) ? ccs_clog2(depth) : 1,
  localparam int cw = ccs_clog2(depth + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          push_req_i,
  input  logic          pop_req_i,
  output logic          push_o,
  output logic          pop_o,
  output logic [aw-1:0] wp_o,
  output logic [aw-1:0] rp_o,
  output logic [cw-1:0] count_o,
  output logic          irdy_o,
  output logic          vld_o
);

  localparam logic [cw-1:0] DepthC = cw'(depth);

  logic [aw-1:0] wp_q, wp_d;
  logic [aw-1:0] rp_q, rp_d;
  logic [cw-1:0] cnt_q, cnt_d;

  assign irdy_o  = (cnt_q != DepthC);
  assign vld_o   = (cnt_q != '0);
  assign push_o  = push_req_i && irdy_o && !clr_i && !rst;
  assign pop_o   = pop_req_i && vld_o && !clr_i && !rst;
  assign wp_o    = wp_q;
  assign rp_o    = rp_q;
  assign count_o = cnt_q;

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_o) wp_d = aw'(ccs_ptr_inc(int'(wp_q), depth));
      if (pop_o)  rp_d = aw'(ccs_ptr_inc(int'(rp_q), depth));
      case ({push_o, pop_o})
        2'b10:   cnt_d = cnt_q + cw'(1);
        2'b01:   cnt_d = cnt_q - cw'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ccs_out_wait_fifo.sv
// First-word-fall-through output port FIFO between a PE core and its consumer.
// Storage and output mux live here; pointer/count control is in ccs_fifo_ctrl.
module ccs_out_wait_fifo
  import ccs_port_pkg::*;
#(
  parameter int rscid = 1,
  parameter int width = 8,
  parameter int depth = 2,
  localparam int cw = ccs_clog2(depth + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] idat,
  input  logic             ivld,
  output logic             irdy,
  output logic [width-1:0] dat,
  output logic             vld,
  input  logic             rdy,
  input  logic             clr,
  output logic [cw-1:0]    sz
);

  localparam int aw = (depth > 1) ? ccs_clog2(depth) : 1;

  // rscid is tool bookkeeping only and produces no hardware.
  if (rscid < 0) begin : g_rscid_unused
  end

  logic             push, pop;
  logic [aw-1:0]    wp, rp;
  logic [width-1:0] mem_q [depth];
  logic [width-1:0] last_q;

  ccs_fifo_ctrl #(.depth(depth)) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (clr),
    .push_req_i(ivld),
    .pop_req_i (rdy),
    .push_o    (push),
    .pop_o     (pop),
    .wp_o      (wp),
    .rp_o      (rp),
    .count_o   (sz),
    .irdy_o    (irdy),
    .vld_o     (vld)
  );

  // last_q keeps dat on the most recently popped word while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      last_q   <= '0;
    end else begin
      if (push) mem_q[wp] <= idat;
      if (pop)  last_q    <= mem_q[rp];
    end
  end

  assign dat = vld ? mem_q[rp] : last_q;

endmodule

// File: tb/tb_ccs_out_wait_fifo.sv
// Bench for ccs_out_wait_fifo: three instances (depth 1, 2, 3) against a queue model.
module tb_ccs_out_wait_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] idat [3];
  logic       ivld [3];
  logic       rdy  [3];
  logic       clr  [3];
  logic [7:0] o_dat [3];
  logic       o_vld [3];
  logic       o_irdy [3];
  logic [0:0] sz_d1;
  logic [1:0] sz_d2, sz_d3;
  int         o_sz [3];

  int checks = 0;
  int failures = 0;

  // Reference model: instance i has depth i+1.
  logic [7:0] mq   [3][$];
  logic [7:0] sent [3][$];
  logic [7:0] mlast [3];
  bit         macc [3];
  bit         m_po, m_pu;

  always #5 clk = ~clk;

  ccs_out_wait_fifo #(.rscid(1), .width(8), .depth(1)) u_d1 (
    .clk(clk), .rst(rst), .idat(idat[0]), .ivld(ivld[0]), .irdy(o_irdy[0]),
    .dat(o_dat[0]), .vld(o_vld[0]), .rdy(rdy[0]), .clr(clr[0]), .sz(sz_d1));
  ccs_out_wait_fifo #(.rscid(2), .width(8), .depth(2)) u_d2 (
    .clk(clk), .rst(rst), .idat(idat[1]), .ivld(ivld[1]), .irdy(o_irdy[1]),
    .dat(o_dat[1]), .vld(o_vld[1]), .rdy(rdy[1]), .clr(clr[1]), .sz(sz_d2));
  ccs_out_wait_fifo #(.rscid(3), .width(8), .depth(3)) u_d3 (
    .clk(clk), .rst(rst), .idat(idat[2]), .ivld(ivld[2]), .irdy(o_irdy[2]),
    .dat(o_dat[2]), .vld(o_vld[2]), .rdy(rdy[2]), .clr(clr[2]), .sz(sz_d3));

  assign o_sz[0] = int'(sz_d1);
  assign o_sz[1] = int'(sz_d2);
  assign o_sz[2] = int'(sz_d3);

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      macc[i] = 1'b0;
      if (rst) begin
        mq[i].delete();
        mlast[i] = 8'h00;
      end else if (clr[i]) begin
        mq[i].delete();
      end else begin
        m_po = rdy[i] && (mq[i].size() > 0);
        m_pu = ivld[i] && (mq[i].size() < i + 1);
        if (m_po) mlast[i] = mq[i].pop_front();
        if (m_pu) begin
          mq[i].push_back(idat[i]);
          sent[i].push_back(idat[i]);
        end
        macc[i] = m_pu;
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ivld[i] = 1'b1; idat[i] = 8'h3C; rdy[i] = 1'b0; clr[i] = 1'b0;
    end
    repeat (2) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (o_vld[i] !== 1'b0 || o_irdy[i] !== 1'b1 || o_sz[i] !== 0 || o_dat[i] !== 8'h00) begin
          failures++;
          $display("FAIL reset[%0d]: vld=%b irdy=%b sz=%0d dat=%h, required vld=0 irdy=1 sz=0 dat=00",
                   i, o_vld[i], o_irdy[i], o_sz[i], o_dat[i]);
        end
      end
    end
    rst = 1'b0;
    ivld[0] = 1'b0; ivld[2] = 1'b0;
    @(negedge clk);
    checks++;
    if (o_sz[1] !== 1 || o_vld[1] !== 1'b1 || o_dat[1] !== 8'h3C) begin
      failures++;
      $display("FAIL first_push: sz=%0d vld=%b dat=%h, required sz=1 vld=1 dat=3c", o_sz[1], o_vld[1], o_dat[1]);
    end
    ivld[1] = 1'b0; rdy[1] = 1'b1;
    @(negedge clk);
    checks++;
    if (o_sz[1] !== 0 || o_vld[1] !== 1'b0 || o_dat[1] !== 8'h3C) begin
      failures++;
      $display("FAIL empty_hold: sz=%0d vld=%b dat=%h, required sz=0 vld=0 dat=3c", o_sz[1], o_vld[1], o_dat[1]);
    end
    rdy[1] = 1'b0;
  endtask

  task automatic test_streaming();
    rdy[1] = 1'b1; ivld[1] = 1'b1; idat[1] = 8'h01;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      checks++;
      if (o_dat[1] !== 8'(k) || o_vld[1] !== 1'b1 || o_sz[1] !== 1 || o_irdy[1] !== 1'b1) begin
        failures++;
        $display("FAIL stream[%0d]: dat=%h vld=%b sz=%0d irdy=%b, required dat=%h vld=1 sz=1 irdy=1",
                 k, o_dat[1], o_vld[1], o_sz[1], o_irdy[1], 8'(k));
      end
      if (k < 16) idat[1] = 8'(k + 1);
      else ivld[1] = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (o_vld[1] !== 1'b0 || o_sz[1] !== 0 || o_dat[1] !== 8'h10) begin
      failures++;
      $display("FAIL stream_end: vld=%b sz=%0d dat=%h, required vld=0 sz=0 dat=10", o_vld[1], o_sz[1], o_dat[1]);
    end
    rdy[1] = 1'b0;
  endtask

  task automatic test_fill_drain();
    logic [7:0] e_dat [4];
    int         e_sz  [4];
    e_dat = '{8'hA1, 8'hA2, 8'hA3, 8'hA3};
    e_sz  = '{2, 2, 1, 0};
    rdy[2] = 1'b0; ivld[2] = 1'b1; idat[2] = 8'hA0;
    @(negedge clk); idat[2] = 8'hA1;
    @(negedge clk); idat[2] = 8'hA2;
    @(negedge clk);
    idat[2] = 8'hA3;
    repeat (3) begin
      checks++;
      if (o_sz[2] !== 3 || o_irdy[2] !== 1'b0 || o_vld[2] !== 1'b1 || o_dat[2] !== 8'hA0) begin
        failures++;
        $display("FAIL full_hold: sz=%0d irdy=%b vld=%b dat=%h, required sz=3 irdy=0 vld=1 dat=a0",
                 o_sz[2], o_irdy[2], o_vld[2], o_dat[2]);
      end
      @(negedge clk);
    end
    rdy[2] = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      checks++;
      if (o_dat[2] !== e_dat[j] || o_sz[2] !== e_sz[j] || o_vld[2] !== (e_sz[j] != 0)) begin
        failures++;
        $display("FAIL drain[%0d]: dat=%h sz=%0d vld=%b, required dat=%h sz=%0d",
                 j, o_dat[2], o_sz[2], o_vld[2], e_dat[j], e_sz[j]);
      end
      if (j == 1) ivld[2] = 1'b0;
    end
    rdy[2] = 1'b0;
  endtask

  task automatic test_flush();
    rdy[1] = 1'b0; ivld[1] = 1'b1; idat[1] = 8'h11;
    @(negedge clk); idat[1] = 8'h22;
    @(negedge clk);
    checks++;
    if (o_sz[1] !== 2) begin
      failures++;
      $display("FAIL flush_pre: sz=%0d, required 2", o_sz[1]);
    end
    clr[1] = 1'b1; idat[1] = 8'h55; rdy[1] = 1'b1;
    @(negedge clk);
    checks++;
    if (o_sz[1] !== 0 || o_vld[1] !== 1'b0 || o_irdy[1] !== 1'b1 || o_dat[1] !== mlast[1]) begin
      failures++;
      $display("FAIL flush: sz=%0d vld=%b irdy=%b dat=%h, required sz=0 vld=0 irdy=1 dat=%h",
               o_sz[1], o_vld[1], o_irdy[1], o_dat[1], mlast[1]);
    end
    clr[1] = 1'b0; ivld[1] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (o_vld[1] !== 1'b0) begin
        failures++;
        $display("FAIL flush_ghost: vld=%b dat=%h, required vld=0", o_vld[1], o_dat[1]);
      end
    end
    rdy[1] = 1'b0; ivld[1] = 1'b1; idat[1] = 8'h66;
    @(negedge clk);
    checks++;
    if (o_vld[1] !== 1'b1 || o_dat[1] !== 8'h66 || o_sz[1] !== 1) begin
      failures++;
      $display("FAIL post_flush: vld=%b dat=%h sz=%0d, required vld=1 dat=66 sz=1", o_vld[1], o_dat[1], o_sz[1]);
    end
    ivld[1] = 1'b0; rdy[1] = 1'b1;
    @(negedge clk);
    rdy[1] = 1'b0;
  endtask

  task automatic test_depth1();
    logic [7:0] obs [$];
    int k;
    k = 0;
    ivld[0] = 1'b1; idat[0] = 8'hC0; rdy[0] = 1'b1;
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      checks++;
      if (o_vld[0] !== ((j % 2) == 1) || o_sz[0] !== (j % 2) ||
          (o_vld[0] === 1'b1 && o_dat[0] !== 8'(8'hC0 + (j - 1) / 2))) begin
        failures++;
        $display("FAIL depth1[%0d]: vld=%b sz=%0d dat=%h, required vld=%0d dat=%h",
                 j, o_vld[0], o_sz[0], o_dat[0], j % 2, 8'(8'hC0 + (j - 1) / 2));
      end
      if (o_vld[0] === 1'b1 && rdy[0]) obs.push_back(o_dat[0]);
      if (macc[0]) begin
        k++;
        idat[0] = 8'(8'hC0 + k);
      end
      if (j == 16) ivld[0] = 1'b0;
    end
    checks++;
    if (obs.size() != 8) begin
      failures++;
      $display("FAIL depth1_count: delivered=%0d, required 8", obs.size());
    end else begin
      for (int n = 0; n < 8; n++) begin
        checks++;
        if (obs[n] !== 8'(8'hC0 + n)) begin
          failures++;
          $display("FAIL depth1_order[%0d]: got %h, required %h", n, obs[n], 8'(8'hC0 + n));
        end
      end
    end
    rdy[0] = 1'b0;
  endtask

  task automatic test_backpressure(input int idx, input int nwords);
    logic [7:0] obs [$];
    int         issued, cyc, bad, n;
    bit         hold_prev;
    logic [7:0] prev_dat;
    issued = 0; cyc = 0; hold_prev = 1'b0; prev_dat = 8'h00;
    sent[idx].delete();
    ivld[idx] = 1'b0; rdy[idx] = 1'b0;
    while ((issued < nwords || ivld[idx] || mq[idx].size() > 0) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      n = mq[idx].size();
      checks++;
      if (o_vld[idx] !== (n != 0) || o_irdy[idx] !== (n != idx + 1) || o_sz[idx] !== n) begin
        failures++;
        $display("FAIL bp_flags[%0d] cyc %0d: vld=%b irdy=%b sz=%0d, required sz=%0d",
                 idx, cyc, o_vld[idx], o_irdy[idx], o_sz[idx], n);
      end
      if (n > 0) begin
        checks++;
        if (o_dat[idx] !== mq[idx][0]) begin
          failures++;
          $display("FAIL bp_data[%0d] cyc %0d: dat=%h, required %h", idx, cyc, o_dat[idx], mq[idx][0]);
        end
      end
      if (hold_prev) begin
        checks++;
        if (o_dat[idx] !== prev_dat) begin
          failures++;
          $display("FAIL bp_hold[%0d] cyc %0d: dat=%h, required %h", idx, cyc, o_dat[idx], prev_dat);
        end
      end
      rdy[idx] = 1'($urandom_range(0, 1));
      if (o_vld[idx] === 1'b1 && rdy[idx]) obs.push_back(o_dat[idx]);
      hold_prev = (o_vld[idx] === 1'b1) && !rdy[idx];
      prev_dat  = o_dat[idx];
      if (!ivld[idx] || macc[idx]) begin
        if (issued < nwords && $urandom_range(0, 3) != 0) begin
          ivld[idx] = 1'b1;
          idat[idx] = 8'($urandom);
          issued++;
        end else begin
          ivld[idx] = 1'b0;
        end
      end
    end
    checks++;
    if (cyc >= 20000) begin
      failures++;
      $display("FAIL bp_timeout[%0d]: %0d cycles, queue=%0d", idx, cyc, mq[idx].size());
    end
    checks++;
    if (obs.size() != nwords || sent[idx].size() != nwords) begin
      failures++;
      $display("FAIL bp_count[%0d]: delivered=%0d accepted=%0d, required %0d", idx, obs.size(), sent[idx].size(), nwords);
    end else begin
      bad = 0;
      for (int m = 0; m < nwords; m++) if (obs[m] !== sent[idx][m]) bad++;
      checks++;
      if (bad != 0) begin
        failures++;
        $display("FAIL bp_order[%0d]: %0d words out of order, required 0", idx, bad);
      end
    end
    rdy[idx] = 1'b0; ivld[idx] = 1'b0;
  endtask

  task automatic test_reset_midstream();
    rdy[2] = 1'b0; ivld[2] = 1'b1; idat[2] = 8'h7E;
    @(negedge clk); idat[2] = 8'h7F;
    @(negedge clk);
    ivld[2] = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (o_vld[i] !== 1'b0 || o_irdy[i] !== 1'b1 || o_sz[i] !== 0 || o_dat[i] !== 8'h00) begin
        failures++;
        $display("FAIL mid_reset[%0d]: vld=%b irdy=%b sz=%0d dat=%h, required 0 1 0 00",
                 i, o_vld[i], o_irdy[i], o_sz[i], o_dat[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_fill_drain();
    test_flush();
    test_depth1();
    test_backpressure(1, 1000);
    test_backpressure(2, 300);
    test_backpressure(0, 200);
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
